// File: rtl/calc1_req_driver.sv
`default_nettype none
// ============================================================================
// Module      : calc1_req_driver
// Description : Request sequencer for one calc1 requester port. Buffers
//               complete operations in a small FIFO, drives calc1's two-cycle
//               request protocol, waits for the port response and offers it
//               on a valid/ready result interface.
//               Optional feature macro: CALC1_REQ_TIMEOUT_EN (response-wait
//               timeout; when undefined WAIT lasts until a response arrives).
// Revision    : 1.0 - initial release
// ============================================================================
module calc1_req_driver #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     c_clk,
  input  logic                     reset,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [3:0]               op_cmd,
  input  logic [31:0]              op_data1,
  input  logic [31:0]              op_data2,
  output logic [3:0]               req_cmd_out,
  output logic [31:0]              req_data_out,
  input  logic [1:0]               calc_resp_in,
  input  logic [31:0]              calc_data_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [1:0]               res_resp,
  output logic [31:0]              res_data,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int                 c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]   c_FULL  = (c_PTR_W + 1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_OPND2 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_capture;
  logic                 w_timeout;
  logic                 w_tmo_hit;

  // FIFO storage and bookkeeping
  logic [3:0]           r_mem_cmd [DEPTH];
  logic [31:0]          r_mem_d1  [DEPTH];
  logic [31:0]          r_mem_d2  [DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;
  logic                 w_push;
  logic                 w_pop;
  logic [3:0]           w_head_cmd;
  logic [31:0]          w_head_d1;
  logic [31:0]          w_head_d2;

  // Operation and output registers
  logic [31:0]          r_op_d2;
  logic [3:0]           r_req_cmd;
  logic [31:0]          r_req_data;
  logic                 r_res_valid;
  logic [1:0]           r_res_resp;
  logic [31:0]          r_res_data;
  logic                 r_busy;

  assign w_push     = op_valid && op_ready;
  assign w_pop      = (r_state == ST_IDLE) && (r_count != '0);
  assign w_head_cmd = r_mem_cmd[r_rd_ptr];
  assign w_head_d1  = r_mem_d1[r_rd_ptr];
  assign w_head_d2  = r_mem_d2[r_rd_ptr];

  // FIFO payload write; contents need no reset since the pointers define validity
  always_ff @(posedge c_clk) begin
    if (w_push) begin
      r_mem_cmd[r_wr_ptr] <= op_cmd;
      r_mem_d1[r_wr_ptr]  <= op_data1;
      r_mem_d2[r_wr_ptr]  <= op_data2;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef CALC1_REQ_TIMEOUT_EN
  localparam int                 c_TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(TIMEOUT - 1);
  logic [c_TMO_W-1:0]            r_tmo;

  // Count WAIT cycles; held at zero outside WAIT so every entry starts fresh
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (r_state != ST_WAIT) begin
      r_tmo <= '0;
    end else if (!w_tmo_hit) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  // The last of TIMEOUT wait cycles has elapsed without a response
  assign w_tmo_hit = (r_state == ST_WAIT) && (r_tmo == c_TMO_LAST);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 0);
  assign w_tmo_hit        = 1'b0;
`endif

  // Next-state selection; a real response wins over a coincident timeout
  always_comb begin
    w_next_state = r_state;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_pop) w_next_state = ST_CMD;
      ST_CMD:   w_next_state = ST_OPND2;
      ST_OPND2: w_next_state = ST_WAIT;
      ST_WAIT: begin
        if (calc_resp_in != 2'b00) begin
          w_next_state = ST_HOLD;
          w_capture    = 1'b1;
        end else if (w_tmo_hit) begin
          w_next_state = ST_HOLD;
          w_timeout    = 1'b1;
        end
      end
      ST_HOLD:  if (res_ready) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // State register plus outputs registered from the upcoming state
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_req_cmd   <= '0;
      r_req_data  <= '0;
      r_res_resp  <= '0;
      r_res_data  <= '0;
      r_op_d2     <= '0;
    end else begin
      r_state     <= w_next_state;
      r_busy      <= (w_next_state != ST_IDLE);
      r_res_valid <= (w_next_state == ST_HOLD);
      if (w_pop) r_op_d2 <= w_head_d2;
      case (w_next_state)
        ST_CMD: begin
          r_req_cmd  <= w_head_cmd;
          r_req_data <= w_head_d1;
        end
        ST_OPND2: begin
          r_req_cmd  <= '0;
          r_req_data <= r_op_d2;
        end
        default: begin
          r_req_cmd  <= '0;
          r_req_data <= '0;
        end
      endcase
      if (w_capture) begin
        r_res_resp <= calc_resp_in;
        r_res_data <= calc_data_in;
      end else if (w_timeout) begin
        r_res_resp <= 2'b00;
        r_res_data <= '0;
      end
    end
  end

  assign op_ready     = (r_count != c_FULL);
  assign fifo_count   = r_count;
  assign req_cmd_out  = r_req_cmd;
  assign req_data_out = r_req_data;
  assign res_valid    = r_res_valid;
  assign res_resp     = r_res_resp;
  assign res_data     = r_res_data;
  assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_calc1_req_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_calc1_req_driver
// Description : Self-checking bench for calc1_req_driver with a calc1 port
//               stub and a queue-based result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_calc1_req_driver;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;

  logic        c_clk        = 1'b0;
  logic        reset        = 1'b0;
  logic        op_valid     = 1'b0;
  logic        op_ready;
  logic [3:0]  op_cmd       = '0;
  logic [31:0] op_data1     = '0;
  logic [31:0] op_data2     = '0;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  calc_resp_in = '0;
  logic [31:0] calc_data_in = '0;
  logic        res_valid;
  logic        res_ready    = 1'b0;
  logic [1:0]  res_resp;
  logic [31:0] res_data;
  logic        busy;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad   = 0;

  calc1_req_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .c_clk(c_clk), .reset(reset),
    .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
    .op_data1(op_data1), .op_data2(op_data2),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_resp(res_resp), .res_data(res_data),
    .busy(busy), .fifo_count(fifo_count)
  );

  always #5 c_clk = ~c_clk;

  // Behaviour of a calc1 port: {resp, data}
  function automatic logic [33:0] calc1_model(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    case (cmd)
      4'd1: begin s = {1'b0, a} + {1'b0, b}; return {(s[32] ? 2'b10 : 2'b01), s[31:0]}; end
      4'd2: return {((a < b) ? 2'b10 : 2'b01), a - b};
      4'd5: return {2'b01, a << b[4:0]};
      4'd6: return {2'b01, a >> b[4:0]};
      default: return {2'b11, 32'd0};
    endcase
  endfunction

  function automatic logic [3:0] rand_cmd();
    logic [3:0] tbl [6];
    tbl[0] = 4'd1; tbl[1] = 4'd2; tbl[2] = 4'd3; tbl[3] = 4'd5; tbl[4] = 4'd6; tbl[5] = 4'd12;
    return tbl[$urandom_range(0, 5)];
  endfunction

  function automatic logic [31:0] rand_opnd();
    return ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 40));
  endfunction

  // calc1 stub: observes the two-cycle request, answers after a random latency
  int          stub_phase  = 0;
  int          stub_wait   = 0;
  logic [3:0]  stub_cmd    = '0;
  logic [31:0] stub_a      = '0;
  logic [33:0] stub_res    = '0;
  bit          stub_silent = 1'b0;
  bit          force_en    = 1'b0;
  logic [1:0]  force_resp  = '0;

  always @(negedge c_clk) begin
    calc_resp_in = 2'b00;
    calc_data_in = 32'd0;
    if (force_en) begin
      calc_resp_in = force_resp;
      calc_data_in = 32'hDEAD_BEEF;
    end
    if (!reset) begin
      stub_phase = 0;
    end else begin
      case (stub_phase)
        0: if (req_cmd_out != 4'd0) begin
             stub_cmd = req_cmd_out; stub_a = req_data_out; stub_phase = 1;
           end
        1: begin
             total++;
             if (req_cmd_out !== 4'd0) begin bad++; $display("FAIL cmd_one_cycle got=%0h exp=0", req_cmd_out); end
             stub_res   = calc1_model(stub_cmd, stub_a, req_data_out);
             stub_wait  = $urandom_range(1, 4);
             stub_phase = 2;
           end
        default: begin
             total++;
             if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0) begin
               bad++; $display("FAIL wait_req_zero got=%0h/%0h exp=0/0", req_cmd_out, req_data_out);
             end
             if (!stub_silent) begin
               stub_wait--;
               if (stub_wait == 0) begin
                 calc_resp_in = stub_res[33:32];
                 calc_data_in = stub_res[31:0];
                 stub_phase   = 0;
               end
             end
           end
      endcase
    end
  end

  // Offer one op starting at a negedge; returns at the negedge after acceptance
  task automatic offer(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, output bit ok);
    int guard = 0;
    op_valid = 1'b1; op_cmd = c; op_data1 = a; op_data2 = b;
    while (!op_ready && guard < 500) begin @(negedge c_clk); guard++; end
    ok = op_ready;
    @(negedge c_clk);
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; op_valid = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge c_clk);
    total++; if (op_ready !== 1'b1)      begin bad++; $display("FAIL rst_op_ready got=%0h exp=1", op_ready); end
    total++; if (res_valid !== 1'b0)     begin bad++; $display("FAIL rst_res_valid got=%0h exp=0", res_valid); end
    total++; if (res_resp !== 2'b00)     begin bad++; $display("FAIL rst_res_resp got=%0h exp=0", res_resp); end
    total++; if (res_data !== 32'd0)     begin bad++; $display("FAIL rst_res_data got=%0h exp=0", res_data); end
    total++; if (req_cmd_out !== 4'd0)   begin bad++; $display("FAIL rst_req_cmd got=%0h exp=0", req_cmd_out); end
    total++; if (req_data_out !== 32'd0) begin bad++; $display("FAIL rst_req_data got=%0h exp=0", req_data_out); end
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (fifo_count !== 3'd0)    begin bad++; $display("FAIL rst_fifo_count got=%0d exp=0", fifo_count); end
    reset = 1'b1;
    @(negedge c_clk);
  endtask

  task automatic test_basic_add();
    int guard = 0;
    op_valid = 1'b1; op_cmd = 4'd1; op_data1 = 32'h0000_0001; op_data2 = 32'h01FF_FFFF;
    @(negedge c_clk);
    op_valid = 1'b0;
    total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL add_count_after_push got=%0d exp=1", fifo_count); end
    total++; if (busy !== 1'b0)       begin bad++; $display("FAIL add_busy_before_pop got=%0h exp=0", busy); end
    @(negedge c_clk);
    total++; if (req_cmd_out !== 4'd1)            begin bad++; $display("FAIL add_cmd_phase got=%0h exp=1", req_cmd_out); end
    total++; if (req_data_out !== 32'h0000_0001)  begin bad++; $display("FAIL add_data1 got=%0h exp=1", req_data_out); end
    total++; if (busy !== 1'b1 || fifo_count !== 3'd0) begin bad++; $display("FAIL add_busy_count got=%0h/%0d exp=1/0", busy, fifo_count); end
    @(negedge c_clk);
    total++; if (req_cmd_out !== 4'd0)            begin bad++; $display("FAIL add_opnd2_cmd got=%0h exp=0", req_cmd_out); end
    total++; if (req_data_out !== 32'h01FF_FFFF)  begin bad++; $display("FAIL add_data2 got=%0h exp=01ffffff", req_data_out); end
    while (!res_valid && guard < 50) begin @(negedge c_clk); guard++; end
    total++; if (res_valid !== 1'b1)              begin bad++; $display("FAIL add_res_valid got=%0h exp=1", res_valid); end
    total++; if (res_resp !== 2'b01)              begin bad++; $display("FAIL add_res_resp got=%0h exp=1", res_resp); end
    total++; if (res_data !== 32'h0200_0000)      begin bad++; $display("FAIL add_res_data got=%0h exp=02000000", res_data); end
    @(negedge c_clk);
    total++; if (res_valid !== 1'b1 || res_data !== 32'h0200_0000) begin bad++; $display("FAIL add_hold_stable got=%0h/%0h exp=1/02000000", res_valid, res_data); end
    res_ready = 1'b1;
    @(negedge c_clk);
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_consumed got=%0h/%0h exp=0/0", res_valid, busy); end
  endtask

  task automatic test_resp_codes();
    logic [3:0]  cmds [4];
    logic [31:0] as   [4];
    logic [31:0] bs   [4];
    logic [1:0]  exp_resp [4];
    bit ok;
    int idx = 0;
    int guard = 0;
    cmds[0] = 4'd1; as[0] = 32'hFFFF_FFFF; bs[0] = 32'h1; exp_resp[0] = 2'b10;
    cmds[1] = 4'd2; as[1] = 32'h0;         bs[1] = 32'h1; exp_resp[1] = 2'b10;
    cmds[2] = 4'd3; as[2] = 32'h1234_5678; bs[2] = 32'h9; exp_resp[2] = 2'b11;
    cmds[3] = 4'd1; as[3] = 32'h0;         bs[3] = 32'h0; exp_resp[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      offer(cmds[i], as[i], bs[i], ok);
      total++; if (!ok) begin bad++; $display("FAIL codes_push%0d got=0 exp=1", i); end
    end
    res_ready = 1'b1;
    while (idx < 4 && guard < 300) begin
      if (res_valid) begin
        total++; if (res_resp !== exp_resp[idx]) begin bad++; $display("FAIL codes_resp%0d got=%0h exp=%0h", idx, res_resp, exp_resp[idx]); end
        if (idx == 3) begin
          total++; if (res_data !== 32'd0) begin bad++; $display("FAIL codes_add_zero_data got=%0h exp=0", res_data); end
        end
        idx++;
      end
      @(negedge c_clk); guard++;
    end
    res_ready = 1'b0;
    total++; if (idx != 4) begin bad++; $display("FAIL codes_count got=%0d exp=4", idx); end
  endtask

  task automatic test_fill();
    logic [33:0] exp_q [$];
    logic [3:0]  c;
    logic [31:0] a, b;
    logic [33:0] e;
    bit ok;
    int idx = 0;
    int guard = 0;
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      c = rand_cmd(); a = rand_opnd(); b = rand_opnd();
      offer(c, a, b, ok);
      total++; if (!ok) begin bad++; $display("FAIL fill_push%0d got=0 exp=1", i); end
      exp_q.push_back(calc1_model(c, a, b));
    end
    total++; if (fifo_count !== 3'(DEPTH)) begin bad++; $display("FAIL fill_count got=%0d exp=%0d", fifo_count, DEPTH); end
    total++; if (op_ready !== 1'b0)        begin bad++; $display("FAIL fill_op_ready got=%0h exp=0", op_ready); end
    repeat (10) @(negedge c_clk);
    total++; if (res_valid !== 1'b1 || fifo_count !== 3'(DEPTH)) begin bad++; $display("FAIL fill_stall got=%0h/%0d exp=1/%0d", res_valid, fifo_count, DEPTH); end
    res_ready = 1'b1;
    while (idx < DEPTH + 1 && guard < 400) begin
      if (res_valid) begin
        e = exp_q.pop_front();
        total++; if ({res_resp, res_data} !== e) begin bad++; $display("FAIL fill_result%0d got=%0h/%0h exp=%0h/%0h", idx, res_resp, res_data, e[33:32], e[31:0]); end
        idx++;
      end
      @(negedge c_clk); guard++;
    end
    res_ready = 1'b0;
    total++; if (idx != DEPTH + 1) begin bad++; $display("FAIL fill_drain_count got=%0d exp=%0d", idx, DEPTH + 1); end
  endtask

  task automatic test_random();
    logic [33:0] exp_q [$];
    int n_ops = 40;
    int got = 0;
    fork
      begin
        for (int i = 0; i < n_ops; i++) begin
          int guard = 0;
          int gap;
          op_valid = 1'b1; op_cmd = rand_cmd(); op_data1 = rand_opnd(); op_data2 = rand_opnd();
          while (!op_ready && guard < 2000) begin @(negedge c_clk); guard++; end
          exp_q.push_back(calc1_model(op_cmd, op_data1, op_data2));
          @(negedge c_clk);
          op_valid = 1'b0;
          gap = $urandom_range(0, 3);
          repeat (gap) @(negedge c_clk);
        end
      end
      begin
        int guard = 0;
        logic [33:0] e;
        while (got < n_ops && guard < 5000) begin
          @(negedge c_clk); guard++;
          res_ready = ($urandom_range(0, 2) != 0);
          if (res_valid && res_ready) begin
            total++;
            if (exp_q.size() == 0) begin
              bad++; $display("FAIL rand_unexpected got=%0h/%0h exp=none", res_resp, res_data);
            end else begin
              e = exp_q.pop_front();
              if ({res_resp, res_data} !== e) begin bad++; $display("FAIL rand_result%0d got=%0h/%0h exp=%0h/%0h", got, res_resp, res_data, e[33:32], e[31:0]); end
            end
            got++;
          end
        end
      end
    join
    @(negedge c_clk);
    res_ready = 1'b0;
    total++; if (got != n_ops) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", got, n_ops); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int guard = 0;
    stub_silent = 1'b1; res_ready = 1'b0;
    offer(4'd1, 32'h11, 32'hA5A5_0002, ok);
    offer(4'd2, 32'h22, 32'h1, ok);
    offer(4'd5, 32'h33, 32'h2, ok);
    while (req_data_out !== 32'hA5A5_0002 && guard < 50) begin @(negedge c_clk); guard++; end
    total++; if (req_data_out !== 32'hA5A5_0002) begin bad++; $display("FAIL mid_reach_opnd2 got=%0h exp=a5a50002", req_data_out); end
    @(negedge c_clk);
    #2 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || fifo_count !== 3'd0) begin bad++; $display("FAIL mid_async_busy_count got=%0h/%0d exp=0/0", busy, fifo_count); end
    total++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0) begin bad++; $display("FAIL mid_async_req got=%0h/%0h exp=0/0", req_cmd_out, req_data_out); end
    total++; if (op_ready !== 1'b1 || res_valid !== 1'b0 || res_resp !== 2'b00 || res_data !== 32'd0) begin
      bad++; $display("FAIL mid_async_res got=%0h/%0h/%0h/%0h exp=1/0/0/0", op_ready, res_valid, res_resp, res_data);
    end
    @(negedge c_clk);
    reset = 1'b1;
    stub_silent = 1'b0;
    force_en = 1'b1; force_resp = 2'b01;
    for (int i = 0; i < 10; i++) begin
      @(negedge c_clk);
      if (i == 3) force_en = 1'b0;
      total++; if (res_valid !== 1'b0 || busy !== 1'b0 || req_cmd_out !== 4'd0) begin
        bad++; $display("FAIL mid_post_reset%0d got=%0h/%0h/%0h exp=0/0/0", i, res_valid, busy, req_cmd_out);
      end
    end
    force_en = 1'b0;
  endtask

`ifdef CALC1_REQ_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int guard = 0;
    int cnt = 0;
    stub_silent = 1'b1; res_ready = 1'b0;
    offer(4'd1, 32'h5, 32'hC0DE_0002, ok);
    while (req_data_out !== 32'hC0DE_0002 && guard < 50) begin @(negedge c_clk); guard++; end
    while (!res_valid && cnt < 200) begin @(negedge c_clk); cnt++; end
    total++; if (cnt != TIMEOUT + 1) begin bad++; $display("FAIL tmo_latency got=%0d exp=%0d", cnt, TIMEOUT + 1); end
    total++; if (res_resp !== 2'b00 || res_data !== 32'd0) begin bad++; $display("FAIL tmo_result got=%0h/%0h exp=0/0", res_resp, res_data); end
    force_en = 1'b1; force_resp = 2'b01;
    repeat (2) @(negedge c_clk);
    force_en = 1'b0;
    total++; if (res_valid !== 1'b1 || res_resp !== 2'b00 || res_data !== 32'd0) begin bad++; $display("FAIL tmo_late_ignored got=%0h/%0h/%0h exp=1/0/0", res_valid, res_resp, res_data); end
    res_ready = 1'b1;
    @(negedge c_clk);
    res_ready = 1'b0;
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL tmo_consumed got=%0h exp=0", res_valid); end
    reset = 1'b0;
    @(negedge c_clk);
    reset = 1'b1;
    stub_silent = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_resp_codes();
    test_fill();
    test_random();
    test_reset_mid();
`ifdef CALC1_REQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
